// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encoding, FSM states, default widths.
package muldiv_pkg;

  localparam int MD_XLEN  = 32;
  localparam int MD_CNT_W = 6;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (output start, op, a, b, hi_we, lo_we, wdata,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, a, b, hi_we, lo_we, wdata,
                  output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit_div_iter.sv
// Restoring divider datapath: one quotient bit per step on magnitudes, sign fix-up on the
// outputs, which reflect the result after the current step (captured on the final step).
module div_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_signed,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
  logic            neg_quo_q, neg_rem_q, div_zero_q;
  logic            a_neg, b_neg, fits;
  logic [XLEN-1:0] a_mag, b_mag, rem_n, quo_n;
  logic [XLEN:0]   shifted, diff;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    a_neg   = is_signed & a[XLEN-1];
    b_neg   = is_signed & b[XLEN-1];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvsr_q};
    fits    = ~diff[XLEN];
    rem_n   = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_n   = {quo_q[XLEN-2:0], fits};
    // A zero divisor yields an all-ones quotient; keep it unsigned so it reads 0xFFFF_FFFF.
    quot    = (neg_quo_q && !div_zero_q) ? -quo_n : quo_n;
    rem     = neg_rem_q ? -rem_n : rem_n;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (load) begin
      rem_q      <= '0;
      quo_q      <= a_mag;
      dvsr_q     <= b_mag;
      neg_quo_q  <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      div_zero_q <= (b == '0);
    end else if (step) begin
      rem_q      <= rem_n;
      quo_q      <= quo_n;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Define MULDIV_FAST_MULT_EN to replace the
// shift-add multiplier with a single-cycle combinational one (divides stay iterative).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = MD_CNT_W
) (
  input logic      clk,
  input logic      rst,
  muldiv_if.slave  bus
);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              is_div_q, done_q;
  logic [XLEN-1:0]   hi_q, lo_q;
  logic              accept, last_iter, go_run;
  logic              mul_wr, div_wr;
  logic [2*XLEN-1:0] mul_res;
  logic [XLEN-1:0]   div_quot, div_rem;

  assign accept    = (state_q == IDLE) && bus.start;
  assign last_iter = (state_q == RUN) && (cnt_q == CNT_W'(XLEN-1));
  assign div_wr    = last_iter && is_div_q;

`ifdef MULDIV_FAST_MULT_EN
  logic [2*XLEN-1:0] a_ext, b_ext;
  logic              sgn;

  always_comb begin
    sgn     = op_is_signed(bus.op);
    a_ext   = {{XLEN{sgn & bus.a[XLEN-1]}}, bus.a};
    b_ext   = {{XLEN{sgn & bus.b[XLEN-1]}}, bus.b};
    mul_res = a_ext * b_ext;
  end
  assign mul_wr = accept && !op_is_div(bus.op);
  assign go_run = accept && op_is_div(bus.op);
`else
  logic [XLEN-1:0]   mcand_q, ph_q, pl_q;
  logic              mneg_q, msgn;
  logic [XLEN:0]     madd;
  logic [2*XLEN-1:0] mstep;

  // Right-shifting accumulator: the multiplier drains out of pl_q as product bits fill in.
  always_comb begin
    msgn    = op_is_signed(bus.op);
    madd    = {1'b0, ph_q} + (pl_q[0] ? {1'b0, mcand_q} : '0);
    mstep   = {madd, pl_q[XLEN-1:1]};
    mul_res = mneg_q ? -mstep : mstep;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      ph_q    <= '0;
      pl_q    <= '0;
      mneg_q  <= 1'b0;
    end else if (accept && !op_is_div(bus.op)) begin
      mcand_q <= (msgn && bus.a[XLEN-1]) ? -bus.a : bus.a;
      pl_q    <= (msgn && bus.b[XLEN-1]) ? -bus.b : bus.b;
      ph_q    <= '0;
      mneg_q  <= msgn & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
    end else if (state_q == RUN && !is_div_q) begin
      {ph_q, pl_q} <= mstep;
    end
  end
  assign mul_wr = last_iter && !is_div_q;
  assign go_run = accept;
`endif

  div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (accept && op_is_div(bus.op)),
    .step      ((state_q == RUN) && is_div_q),
    .is_signed (op_is_signed(bus.op)),
    .a         (bus.a),
    .b         (bus.b),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go_run) state_d = RUN;
      RUN:     if (last_iter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
    end else if (accept) begin
      cnt_q    <= '0;
      is_div_q <= op_is_div(bus.op);
    end else if (state_q == RUN) begin
      cnt_q    <= last_iter ? '0 : cnt_q + 1'b1;
    end
  end

  // MTHI/MTLO only land when idle and not shadowed by a same-cycle issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (mul_wr) begin
        {hi_q, lo_q} <= mul_res;
        done_q       <= 1'b1;
      end else if (div_wr) begin
        hi_q   <= div_rem;
        lo_q   <= div_quot;
        done_q <= 1'b1;
      end else if (state_q == IDLE && !bus.start) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  start_while_busy_a: assert property (@(posedge clk) disable iff (rst) !(bus.busy && bus.start))
    else $error("start issued while busy");

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, alongside the ALU; it owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- HI/LO outputs feed the execute operand mux so that MFHI/MFLO results enter the ALU datapath.
- Busy output is consumed by the hazard unit to stall MFHI/MFLO and further mul/div issues.

Parameters:
- XLEN, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  issue request for a mul/div op, qualified by op
- op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- a  input  XLEN  rs operand (multiplicand / dividend)
- b  input  XLEN  rt operand (multiplier / divisor)
- hi_we  input  1  MTHI write strobe
- lo_we  input  1  MTLO write strobe
- wdata  input  XLEN  MTHI/MTLO data
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse when HI/LO are updated by an op
- hi  output  XLEN  HI register
- lo  output  XLEN  LO register

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high, sampled on the rising edge.
- Reset values: busy=0, done=0, hi=0, lo=0, state=IDLE, counter=0.
- Reset mid-operation aborts the op. HI/LO are cleared and no done pulse is produced.
- FSM states:
  - IDLE: start=1 at edge E0 latches a, b and op, then goes to RUN with counter=0.
  - RUN: one iteration per edge. After the XLEN-th iteration (edge E32 for XLEN=32) go to IDLE.
  - FINISH is folded into the E32 edge: HI/LO are written and done=1 during the following cycle.
- busy is 1 from E0+ through E32- and 0 after E32. Back-to-back: start may be accepted at E33.
- Multiply:
  - Shift-add, 2·XLEN-bit product; {hi,lo} = product.
  - MULT uses magnitudes internally; the product is negated at completion if the sign of a XOR sign of b is 1.
- Divide:
  - Restoring, one quotient bit per cycle; lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divide by zero (any signedness): lo=0xFFFFFFFF, hi=a. Full latency is kept; no exception.
- Start while busy: ignored, no state change. The hazard unit must never do this; assertion only.
- MTHI/MTLO:
  - hi_we or lo_we while idle writes wdata at that edge, visible next cycle; done is not pulsed.
  - hi_we/lo_we while busy: ignored.
  - hi_we and lo_we together: both registers get wdata.
  - start together with hi_we/lo_we in IDLE: start wins, the writes are dropped.
- hi/lo outputs are registered; they hold their old values while busy.

Optional Feature:
- Macro MULDIV_FAST_MULT_EN.
- Defined:
  - MULT/MULTU use a single-cycle combinational multiplier. The product is written at E0, done=1 in the next cycle, busy is never raised.
  - DIV/DIVU are unchanged.
- Undefined:
  - Iterative multiply as above.
  - No combinational multiplier is instantiated.

Decomposition:
- Shared package muldiv_pkg:
  - op encoding constants MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3
  - FSM state typedef {IDLE, RUN}
  - XLEN default
- Natural sub-module div_iter: restoring-divide datapath step holding remainder/quotient shift registers, with magnitude and sign fix-up at completion.
- The multiply shift-add stays in muldiv_unit.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5:
  - busy high for 32 cycles; done at cycle 33 after the start edge.
  - hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 -> lo=14, hi=2.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678.
- Reset and MTHI/MTLO interactions:
  - Start DIVU, assert rst at iteration 10 -> busy=0, hi=lo=0, no done.
  - hi_we with wdata=0xAAAA5555 while busy -> hi unchanged.
  - The same write in IDLE -> hi=0xAAAA5555 next cycle.
  - With MULDIV_FAST_MULT_EN: MULT 6×7 -> lo=42 one cycle after start, busy never 1.
